// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the limb-serial wide adder scheduler.
package wide_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Number of limb cycles needed for one full-width operation.
  function automatic int NLIMB(input int width, input int limb);
    return width / limb;
  endfunction

  // Limb counter width; kept at least one bit so a single-limb build still has a counter.
  function automatic int CNT_W(input int nlimb);
    return (nlimb > 1) ? $clog2(nlimb) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sched_if.sv
// Request/response bus between operand producers, the scheduler and the result consumer.
interface wide_add_sched_if #(
  parameter int WIDTH = 1024,
  parameter int NREQ  = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  busy;

  modport master (
    output req_valid, req_sub, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_sub, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );
endinterface

// File: rtl/add_limb.sv
// One LIMB-wide add slice; inv_b turns it into the a + ~b + cin half of a subtract.
module add_limb #(
  parameter int LIMB = 256
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  input  logic            inv_b,
  output logic [LIMB-1:0] s,
  output logic            cout
);
  logic [LIMB-1:0] b_eff;

  // Carry-in plus optional inversion of b gives two's-complement subtract across limbs.
  always_comb begin
    b_eff       = inv_b ? ~b : b;
    {cout, s}   = {1'b0, a} + {1'b0, b_eff} + {{LIMB{1'b0}}, cin};
  end
endmodule

// File: rtl/wide_add_sched.sv
// Round-robin scheduler feeding one shared LIMB-wide adder; each job runs LSB limb first.
module wide_add_sched
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 256,
  parameter int NREQ  = 2
) (
  input logic             clk,
  input logic             rst_n,
  wide_add_sched_if.slave bus
);
  localparam int NL  = NLIMB(WIDTH, LIMB);
  localparam int CW  = CNT_W(NL);
  localparam int IDW = $clog2(NREQ);

  // First valid requester after ptr, wrapping; msb of the result flags "found".
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (v[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d, rsp_carry_q, rsp_carry_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   id_q, id_d, rr_q, rr_d;
  logic [CW-1:0]    k_q, k_d;

  logic [IDW:0]     pick;
  logic [IDW-1:0]   grant;
  logic             accept;
  logic [NREQ-1:0]  ready;
  logic [LIMB-1:0]  a_limb, b_limb, s_limb;
  logic             c_limb;

  // Grant only from IDLE and never while reset is asserted.
  always_comb begin
    pick   = rr_pick(bus.req_valid, rr_q);
    grant  = pick[IDW-1:0];
    accept = rst_n && (state_q == IDLE) && pick[IDW];
    ready  = '0;
    if (accept) ready[grant] = 1'b1;
  end

  assign a_limb = a_q[int'(k_q)*LIMB +: LIMB];
  assign b_limb = b_q[int'(k_q)*LIMB +: LIMB];

  add_limb #(.LIMB(LIMB)) u_add_limb (
    .a     (a_limb),
    .b     (b_limb),
    .cin   (carry_q),
    .inv_b (sub_q),
    .s     (s_limb),
    .cout  (c_limb)
  );

  // Next-state: capture on accept, one limb per RUN cycle, hold result in DONE until taken.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    id_d        = id_q;
    rr_d        = rr_q;
    carry_d     = carry_q;
    k_d         = k_q;
    sum_d       = sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d     = bus.req_a[int'(grant)*WIDTH +: WIDTH];
        b_d     = bus.req_b[int'(grant)*WIDTH +: WIDTH];
        sub_d   = bus.req_sub[grant];
        carry_d = bus.req_sub[grant];
        id_d    = grant;
        rr_d    = grant;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[int'(k_q)*LIMB +: LIMB] = s_limb;
        carry_d = c_limb;
        if (k_q == CW'(NL-1)) begin
          k_d         = '0;
          rsp_carry_d = c_limb;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      DONE: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any job in flight so its result is never presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      rr_q        <= IDW'(NREQ-1);
      carry_q     <= 1'b0;
      k_q         <= '0;
      sum_q       <= '0;
      rsp_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      sum_q       <= sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
